// File: rtl/corr_pkg.sv
// corr_pkg: shared state type, default widths and accumulator sizing for the correlator.
package corr_pkg;
  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;
  localparam int N_DEF = 1024;
  localparam int DW_DEF = 16;
  localparam int OW_DEF = 32;
  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + 1 + $clog2(n);
  endfunction
endpackage

// File: rtl/design1_wrapper_mac.sv
// complex_mac: complex multiply (optionally conjugating h) plus accumulate, 2-cycle latency.
module complex_mac #(
  parameter int DW = 16,
  parameter int AW = 43
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          conj,
  input  logic [DW-1:0] xr,
  input  logic [DW-1:0] xi,
  input  logic [DW-1:0] hr,
  input  logic [DW-1:0] hi,
  output logic [AW-1:0] acc_re,
  output logic [AW-1:0] acc_im
);
  localparam int PW = 2 * DW + 1;
  logic signed [PW-1:0] xr_e, xi_e, hr_e, hi_e, rr, ii, ir, ri, p_re, p_im;
  logic v;
  assign xr_e = PW'($signed(xr));
  assign xi_e = PW'($signed(xi));
  assign hr_e = PW'($signed(hr));
  assign hi_e = PW'($signed(hi));
  assign rr = xr_e * hr_e;
  assign ii = xi_e * hi_e;
  assign ir = xi_e * hr_e;
  assign ri = xr_e * hi_e;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= 1'b0;
      p_re <= '0;
      p_im <= '0;
      acc_re <= '0;
      acc_im <= '0;
    end else if (clr) begin
      v <= 1'b0;
      acc_re <= '0;
      acc_im <= '0;
    end else begin
      v <= en;
      if (en) begin
        p_re <= conj ? rr + ii : rr - ii;
        p_im <= conj ? ir - ri : ir + ri;
      end
      if (v) begin
        acc_re <= acc_re + AW'(p_re);
        acc_im <= acc_im + AW'(p_im);
      end
    end
endmodule

// File: rtl/design1_wrapper.sv
// design1_wrapper: frame-based circular complex correlator built around one serial complex MAC.
// Define CORR_SAT_EN to saturate the shifted accumulator to OW bits instead of wrapping.
module design1_wrapper
  import corr_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [15:0]   FFT_CONFIG_tdata,
  input  logic          FFT_CONFIG_tvalid,
  output logic          FFT_CONFIG_tready,
  input  logic [23:0]   IFFT_CONFIG_tdata,
  input  logic          IFFT_CONFIG_tvalid,
  output logic          IFFT_CONFIG_tready,
  input  logic [DW-1:0] SF_RE_tdata,
  input  logic [DW-1:0] SF_IM_tdata,
  input  logic          SF_RE_tvalid,
  input  logic          SF_IM_tvalid,
  output logic          SF_RE_tready,
  output logic          SF_IM_tready,
  input  logic [DW-1:0] S_AXIS_RE_tdata,
  input  logic [DW-1:0] S_AXIS_IM_tdata,
  input  logic          S_AXIS_RE_tvalid,
  input  logic          S_AXIS_IM_tvalid,
  input  logic          S_AXIS_RE_tlast,
  input  logic          S_AXIS_IM_tlast,
  output logic          S_AXIS_RE_tready,
  output logic          S_AXIS_IM_tready,
  output logic [OW-1:0] M_AXIS_RE_tdata,
  output logic [OW-1:0] M_AXIS_IM_tdata,
  output logic          M_AXIS_RE_tvalid,
  output logic          M_AXIS_IM_tvalid,
  input  logic          M_AXIS_RE_tready,
  input  logic          M_AXIS_IM_tready,
  output logic          M_AXIS_RE_tlast
);
  localparam int LW = $clog2(N);
  localparam int AW = acc_w(DW, N);
  state_t st, st_n;
  logic [LW:0] ref_cnt, rx_cnt;
  logic [LW+1:0] cnt;
  logic [LW-1:0] lag;
  logic p_conj, cfg_conj;
  logic [4:0] p_shift, shift;
  logic [2*DW-1:0] h_ram [N];
  logic [2*DW-1:0] x_ram [N];
  logic [2*DW-1:0] h_q, x_q;
  logic rd_v, ref_acc, rx_acc, ref_done, rx_done, go, fin, hs, cfg_rdy;
  logic [AW-1:0] acc_re, acc_im;
  logic signed [AW-1:0] sh_re, sh_im;
  logic unused;
  assign unused = ^{S_AXIS_RE_tlast, S_AXIS_IM_tlast, FFT_CONFIG_tdata[15:1], IFFT_CONFIG_tdata[23:5]};
`ifdef CORR_SAT_EN
  function automatic logic [OW-1:0] fit(input logic [AW-1:0] v);
    return (&v[AW-1:OW-1] || ~|v[AW-1:OW-1]) ? v[OW-1:0] : {v[AW-1], {(OW-1){~v[AW-1]}}};
  endfunction
`else
  function automatic logic [OW-1:0] fit(input logic [AW-1:0] v);
    return v[OW-1:0];
  endfunction
`endif
  assign cfg_rdy = !aresetn && st == LOAD;
  assign FFT_CONFIG_tready = cfg_rdy;
  assign IFFT_CONFIG_tready = cfg_rdy;
  assign SF_RE_tready = cfg_rdy && !ref_cnt[LW];
  assign SF_IM_tready = SF_RE_tready;
  assign S_AXIS_RE_tready = cfg_rdy && !rx_cnt[LW];
  assign S_AXIS_IM_tready = S_AXIS_RE_tready;
  assign ref_acc = SF_RE_tready && SF_RE_tvalid && SF_IM_tvalid;
  assign rx_acc = S_AXIS_RE_tready && S_AXIS_RE_tvalid && S_AXIS_IM_tvalid;
  // a stream is done if already full or its final sample is accepted this cycle
  assign ref_done = ref_cnt[LW] || (ref_acc && &ref_cnt[LW-1:0]);
  assign rx_done = rx_cnt[LW] || (rx_acc && &rx_cnt[LW-1:0]);
  assign go = st == LOAD && ref_done && rx_done;
  assign fin = st == COMPUTE && cnt == (LW+2)'(N + 1);
  assign hs = st == OUTPUT && M_AXIS_RE_tready && M_AXIS_IM_tready;
  always_comb begin
    st_n = st;
    if (go) st_n = COMPUTE;
    else if (fin) st_n = OUTPUT;
    else if (hs) st_n = &lag ? LOAD : COMPUTE;
  end
  always_ff @(posedge aclk or posedge aresetn)
    if (aresetn) begin
      st <= LOAD;
      ref_cnt <= '0;
      rx_cnt <= '0;
      cnt <= '0;
      lag <= '0;
      rd_v <= 1'b0;
      p_conj <= 1'b1;
      p_shift <= '0;
      cfg_conj <= 1'b1;
      shift <= '0;
    end else begin
      st <= st_n;
      if (go) begin
        ref_cnt <= '0;
        rx_cnt <= '0;
        cfg_conj <= p_conj;
        shift <= p_shift;
      end else begin
        if (ref_acc) ref_cnt <= ref_cnt + (LW+1)'(1);
        if (rx_acc) rx_cnt <= rx_cnt + (LW+1)'(1);
      end
      if (FFT_CONFIG_tvalid && cfg_rdy) p_conj <= FFT_CONFIG_tdata[0];
      if (IFFT_CONFIG_tvalid && cfg_rdy) p_shift <= IFFT_CONFIG_tdata[4:0];
      cnt <= st == COMPUTE ? cnt + (LW+2)'(1) : '0;
      rd_v <= st == COMPUTE && cnt < (LW+2)'(N);
      if (hs) lag <= lag + LW'(1);
    end
  always_ff @(posedge aclk) begin
    if (ref_acc) h_ram[ref_cnt[LW-1:0]] <= {SF_IM_tdata, SF_RE_tdata};
    if (rx_acc) x_ram[rx_cnt[LW-1:0]] <= {S_AXIS_IM_tdata, S_AXIS_RE_tdata};
    h_q <= h_ram[cnt[LW-1:0]];
    x_q <= x_ram[cnt[LW-1:0] + lag];
  end
  complex_mac #(.DW(DW), .AW(AW)) u_mac (
    .clk(aclk),
    .rst(aresetn),
    .clr(go || hs),
    .en(rd_v),
    .conj(cfg_conj),
    .xr(x_q[DW-1:0]),
    .xi(x_q[2*DW-1:DW]),
    .hr(h_q[DW-1:0]),
    .hi(h_q[2*DW-1:DW]),
    .acc_re(acc_re),
    .acc_im(acc_im)
  );
  assign sh_re = $signed(acc_re) >>> shift;
  assign sh_im = $signed(acc_im) >>> shift;
  assign M_AXIS_RE_tvalid = st == OUTPUT;
  assign M_AXIS_IM_tvalid = st == OUTPUT;
  assign M_AXIS_RE_tlast = st == OUTPUT && &lag;
  assign M_AXIS_RE_tdata = st == OUTPUT ? fit(sh_re) : '0;
  assign M_AXIS_IM_tdata = st == OUTPUT ? fit(sh_im) : '0;
endmodule

// File: tb/tb_design1_wrapper.sv
// tb_design1_wrapper: table-driven frame tests with a per-lag scoreboard for the correlator.
module tb_design1_wrapper;
  localparam int N = 16;
`ifdef CORR_SAT_EN
  localparam logic [31:0] SAT_EXP = 32'h7FFFFFFF;
`else
  localparam logic [31:0] SAT_EXP = 32'hFFF00010;
`endif
  typedef struct {
    int pat;
    bit cfg;
    bit conj;
    int shift;
    bit bp;
    int lag;
    logic [31:0] re;
    logic [31:0] im;
  } tv_t;
  tv_t tv [7];
  logic aclk = 0, aresetn = 1;
  logic [15:0] fft_d = 0;
  logic [23:0] ifft_d = 0;
  logic fft_v = 0, ifft_v = 0, fft_r, ifft_r;
  logic [15:0] sf_re = 0, sf_im = 0, s_re = 0, s_im = 0;
  logic sf_v = 0, s_v = 0, sf_r_re, sf_r_im, s_r_re, s_r_im;
  logic [31:0] m_re, m_im;
  logic m_v_re, m_v_im, m_last, m_rdy = 1;
  int h_re [N], h_im [N], x_re [N], x_im [N];
  logic [31:0] exp_re [$], exp_im [$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;
  design1_wrapper #(.N(N), .DW(16), .OW(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .FFT_CONFIG_tdata(fft_d), .FFT_CONFIG_tvalid(fft_v), .FFT_CONFIG_tready(fft_r),
    .IFFT_CONFIG_tdata(ifft_d), .IFFT_CONFIG_tvalid(ifft_v), .IFFT_CONFIG_tready(ifft_r),
    .SF_RE_tdata(sf_re), .SF_IM_tdata(sf_im), .SF_RE_tvalid(sf_v), .SF_IM_tvalid(sf_v),
    .SF_RE_tready(sf_r_re), .SF_IM_tready(sf_r_im),
    .S_AXIS_RE_tdata(s_re), .S_AXIS_IM_tdata(s_im), .S_AXIS_RE_tvalid(s_v), .S_AXIS_IM_tvalid(s_v),
    .S_AXIS_RE_tlast(1'b0), .S_AXIS_IM_tlast(1'b0),
    .S_AXIS_RE_tready(s_r_re), .S_AXIS_IM_tready(s_r_im),
    .M_AXIS_RE_tdata(m_re), .M_AXIS_IM_tdata(m_im), .M_AXIS_RE_tvalid(m_v_re), .M_AXIS_IM_tvalid(m_v_im),
    .M_AXIS_RE_tready(m_rdy), .M_AXIS_IM_tready(m_rdy), .M_AXIS_RE_tlast(m_last)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] red(input longint v);
`ifdef CORR_SAT_EN
    if (v > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (v < -64'sh80000000) return 32'h80000000;
`endif
    return v[31:0];
  endfunction
  task automatic fill(input int pat);
    for (int n = 0; n < N; n++) begin
      h_re[n] = 0; h_im[n] = 0; x_re[n] = 0; x_im[n] = 0;
      if (pat == 1) begin h_re[n] = 1024; x_re[n] = 1024; end
      if (pat == 3) begin h_re[n] = 32767; x_re[n] = 32767; end
      if (pat == 4) begin
        h_re[n] = int'($urandom_range(200)) - 100; h_im[n] = int'($urandom_range(200)) - 100;
        x_re[n] = int'($urandom_range(200)) - 100; x_im[n] = int'($urandom_range(200)) - 100;
      end
      if (pat == 5) begin
        h_re[n] = int'($urandom_range(65535)) - 32768; h_im[n] = int'($urandom_range(65535)) - 32768;
        x_re[n] = int'($urandom_range(65535)) - 32768; x_im[n] = int'($urandom_range(65535)) - 32768;
      end
    end
    if (pat == 0) begin h_re[0] = 1; x_re[5] = 1; end
    if (pat == 2) begin h_im[0] = 1; x_im[0] = 1; end
  endtask
  task automatic push_model(input bit cj, input int sh);
    longint re, im, xr, xi, hr, hi;
    for (int k = 0; k < N; k++) begin
      re = 0; im = 0;
      for (int n = 0; n < N; n++) begin
        xr = x_re[(n + k) % N]; xi = x_im[(n + k) % N]; hr = h_re[n]; hi = h_im[n];
        re += cj ? xr * hr + xi * hi : xr * hr - xi * hi;
        im += cj ? xi * hr - xr * hi : xi * hr + xr * hi;
      end
      exp_re.push_back(red(re >>> sh));
      exp_im.push_back(red(im >>> sh));
    end
  endtask
  task automatic send_cfg(input bit cj, input int sh);
    fft_d = {15'h2AAA, cj};
    ifft_d = {19'h55555, 5'(sh)};
    fft_v = 1; ifft_v = 1;
    @(negedge aclk);
    chk("cfg_ready", {30'd0, fft_r, ifft_r}, 32'd3);
    @(posedge aclk); #1;
    fft_v = 0; ifft_v = 0;
  endtask
  task automatic send_frame(input bit rnd, output int t_last);
    int ri = 0, xi = 0, to = 0;
    t_last = 0;
    while ((ri < N || xi < N) && to < 20 * N) begin
      sf_v = ri < N && (!rnd || $urandom_range(2) != 0);
      s_v = xi < N && (!rnd || $urandom_range(2) != 0);
      sf_re = ri < N ? 16'(h_re[ri]) : 16'd0;
      sf_im = ri < N ? 16'(h_im[ri]) : 16'd0;
      s_re = xi < N ? 16'(x_re[xi]) : 16'd0;
      s_im = xi < N ? 16'(x_im[xi]) : 16'd0;
      @(negedge aclk);
      if (ri == N && xi < N) chk("sf_ready_drop", {31'd0, sf_r_re}, 32'd0);
      if (xi == N && ri < N) chk("s_ready_drop", {31'd0, s_r_re}, 32'd0);
      if (sf_v && sf_r_re && sf_r_im) begin ri++; t_last = cyc; end
      if (s_v && s_r_re && s_r_im) begin xi++; t_last = cyc; end
      @(posedge aclk); #1;
      to++;
    end
    sf_v = 0; s_v = 0;
    if (ri < N || xi < N) chk("load_timeout", 32'(ri + xi), 32'(2 * N));
  endtask
  task automatic collect(input bit bp, input int t0, input int clag, input logic [31:0] cre, input logic [31:0] cim);
    int got = 0, wt = 0, prev = 0;
    bit seen = 0, hold = 0;
    logic [31:0] hre = 0, him = 0, er, ei;
    logic hl = 0;
    while (got < N && wt < 8 * N * (N + 3)) begin
      m_rdy = bp ? (cyc % 3 == 0) : 1'b1;
      @(negedge aclk);
      if (m_v_re && m_v_im) begin
        if (!seen) begin
          seen = 1;
          chk("lag0_latency", 32'(cyc - t0), 32'(N + 3));
        end
        if (hold) begin
          chk("stable_re", m_re, hre);
          chk("stable_im", m_im, him);
          chk("stable_last", {31'd0, m_last}, {31'd0, hl});
        end
        if (m_rdy) begin
          er = exp_re.pop_front();
          ei = exp_im.pop_front();
          chk("lag_re", m_re, er);
          chk("lag_im", m_im, ei);
          chk("tlast", {31'd0, m_last}, {31'd0, got == N - 1});
          if (got == clag) begin
            chk("table_re", m_re, cre);
            chk("table_im", m_im, cim);
          end
          if (!bp && got > 0) chk("lag_period", 32'(cyc - prev), 32'(N + 3));
          prev = cyc;
          got++;
          hold = 0;
        end else begin
          hold = 1; hre = m_re; him = m_im; hl = m_last;
        end
      end
      @(posedge aclk); #1;
      wt++;
    end
    m_rdy = 1;
    chk("beat_count", 32'(got), 32'(N));
    @(negedge aclk);
    chk("no_extra_beat", {31'd0, m_v_re}, 32'd0);
    @(posedge aclk); #1;
  endtask
  task automatic run_test(input int t);
    int t0;
    fill(tv[t].pat);
    if (tv[t].cfg) send_cfg(tv[t].conj, tv[t].shift);
    push_model(tv[t].conj, tv[t].shift);
    send_frame(tv[t].bp, t0);
    collect(tv[t].bp, t0, tv[t].lag, tv[t].re, tv[t].im);
  endtask
  task automatic chk_reset_outputs();
    chk("rst_readies", {26'd0, sf_r_re, sf_r_im, s_r_re, s_r_im, fft_r, ifft_r}, 32'd0);
    chk("rst_valid", {30'd0, m_v_re, m_v_im}, 32'd0);
    chk("rst_data_re", m_re, 32'd0);
    chk("rst_data_im", m_im, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
  endtask
  initial begin
    int t0;
    tv[0] = '{0, 0, 1, 0, 0, 5, 32'd1, 32'd0};
    tv[1] = '{1, 1, 1, 4, 0, 7, 32'd1048576, 32'd0};
    tv[2] = '{2, 1, 1, 0, 0, 0, 32'd1, 32'd0};
    tv[3] = '{2, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'd0};
    tv[4] = '{3, 1, 1, 0, 0, 3, SAT_EXP, 32'd0};
    tv[5] = '{4, 1, 1, 2, 1, -1, 32'd0, 32'd0};
    tv[6] = '{5, 1, 0, 3, 1, -1, 32'd0, 32'd0};
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_reset_outputs();
    @(posedge aclk); #1;
    aresetn = 0;
    @(negedge aclk);
    chk("load_readies", {26'd0, sf_r_re, sf_r_im, s_r_re, s_r_im, fft_r, ifft_r}, 32'h3F);
    @(posedge aclk); #1;
    for (int t = 0; t < 7; t++) run_test(t);
    fill(4);
    send_cfg(0, 2);
    push_model(0, 2);
    send_frame(0, t0);
    repeat (5) @(posedge aclk);
    #1 aresetn = 1;
    @(negedge aclk);
    chk_reset_outputs();
    @(posedge aclk); #1;
    aresetn = 0;
    exp_re.delete();
    exp_im.delete();
    @(negedge aclk);
    chk("post_rst_readies", {26'd0, sf_r_re, sf_r_im, s_r_re, s_r_im, fft_r, ifft_r}, 32'h3F);
    @(posedge aclk); #1;
    fill(5);
    push_model(1, 0);
    send_frame(1, t0);
    collect(0, t0, -1, 32'd0, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
